game_score_display: RTL



---
 rtl/game_score_pkg.sv | 23 ++
 rtl/game_bin2bcd.sv | 59 +++++
 rtl/game_score_display.sv | 104 ++++++++++
 3 files changed

// File: rtl/game_score_pkg.sv
// Shared constants, FSM encoding and 7-segment patterns for the score display.
package game_score_pkg;

  localparam int DIGITS   = 4;
  localparam int BCD_MAX  = 9999;
  localparam int BIN_BITS = 14;
  localparam int BCD_W    = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} score_state_t;

  // {dp,g,f,e,d,c,b,a}, active-high
  localparam logic [7:0] SEG_LUT [0:9] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  // Non-decimal nibbles drive a dark digit rather than garbage
  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    if (n > 4'd9) return 8'h00;
    return SEG_LUT[int'(n)];
  endfunction

endpackage

// File: rtl/game_bin2bcd.sv
// Sequential double-dabble: 14-bit binary to 4-digit BCD, one iteration per cycle.
// start is honoured only in IDLE; done pulses in the LOAD cycle with bcd valid.
module game_bin2bcd
  import game_score_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_BITS-1:0] bin,
  output logic                busy,
  output logic                done,
  output logic [BCD_W-1:0]    bcd
);

  localparam int SH_W = BCD_W + BIN_BITS;

  score_state_t    state;
  logic [3:0]      iter;
  logic [SH_W-1:0] sh;
  logic [SH_W-1:0] sh_adj;

  // add-3 correction on every BCD nibble that would overflow on the next shift
  always_comb begin
    sh_adj = sh;
    for (int d = 0; d < DIGITS; d++) begin
      if (sh[BIN_BITS+4*d +: 4] >= 4'd5)
        sh_adj[BIN_BITS+4*d +: 4] = sh[BIN_BITS+4*d +: 4] + 4'd3;
    end
  end

  // conversion FSM: load, BIN_BITS shift iterations, then one result cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      iter  <= '0;
      sh    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sh    <= {{BCD_W{1'b0}}, bin};
          iter  <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          sh   <= {sh_adj[SH_W-2:0], 1'b0};
          iter <= iter + 4'd1;
          if (iter == 4'(BIN_BITS - 1)) state <= LOAD;
        end
        LOAD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == LOAD);
  assign bcd  = sh[SH_W-1 -: BCD_W];

endmodule

// File: rtl/game_score_display.sv
// Score display: BCD conversion of the live score, session high score and
// multiplexed 7-segment scan. Optional GAME_SCORE_LZ_BLANK_EN blanks leading zeros.
module game_score_display
  import game_score_pkg::*;
#(
  parameter int SCAN_COUNTER_WIDTH = 16,
  parameter int SCORE_WIDTH        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SCORE_WIDTH-1:0] score,
  input  logic                   game_over,
  output logic [7:0]             seg,
  output logic [DIGITS-1:0]      digit_sel,
  output logic [SCORE_WIDTH-1:0] high_score,
  output logic                   busy
);

  logic [SCORE_WIDTH-1:0]        last_score;
  logic                          conv_start;
  logic                          conv_done;
  logic [BIN_BITS-1:0]           conv_bin;
  logic [BCD_W-1:0]              conv_bcd;
  logic [BCD_W-1:0]              disp;
  logic                          go_q;
  logic [SCAN_COUNTER_WIDTH-1:0] scan_cnt;
  logic [1:0]                    idx;
  logic [DIGITS-1:0]             blank;
  logic [3:0]                    nib;
  logic [7:0]                    seg_nxt;

  // Only sample the score while the converter is idle; the newest value wins later
  assign conv_start = !busy && (score != last_score);
  assign conv_bin   = (score > SCORE_WIDTH'(BCD_MAX)) ? BIN_BITS'(BCD_MAX)
                                                      : score[BIN_BITS-1:0];

  game_bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // remember the value handed to the converter; latch the finished BCD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_score <= '0;
      disp       <= '0;
    end else begin
      if (conv_start) last_score <= score;
      if (conv_done)  disp       <= conv_bcd;
    end
  end

  // high score updates once per rising game_over edge, using the edge-cycle score
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      go_q       <= 1'b0;
      high_score <= '0;
    end else begin
      go_q <= game_over;
      if (game_over && !go_q && (score > high_score)) high_score <= score;
    end
  end

  // free-running dwell counter; digit index advances on wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (scan_cnt == {SCAN_COUNTER_WIDTH{1'b1}}) idx <= idx + 2'd1;
    end
  end

  // digit k is blank when it and every higher digit are zero; units never blank
  always_comb begin
    blank = '0;
`ifdef GAME_SCORE_LZ_BLANK_EN
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (k == DIGITS - 1) blank[k] = (disp[4*k +: 4] == 4'd0);
      else                 blank[k] = blank[k+1] && (disp[4*k +: 4] == 4'd0);
    end
`endif
    nib     = disp[{idx, 2'b00} +: 4];
    seg_nxt = blank[idx] ? 8'h00 : seg_decode(nib);
  end

  // registered display drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg       <= 8'h3F;
      digit_sel <= DIGITS'(1);
    end else begin
      seg       <= seg_nxt;
      digit_sel <= DIGITS'(1) << idx;
    end
  end

endmodule
